// File: rtl/seq_shifter.sv
// Iterative shifter: moves the operand one bit per clock under a start/done handshake.
// Build option SEQ_SHIFTER_ARITH_EN enables sign-filling arithmetic right shifts.
module seq_shifter #(
    parameter int WIDTH = 32,
    parameter int SHIFT = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [SHIFT-1:0] b,
    input  logic             dir,
    input  logic             arith,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] o,
    output logic [1:0]       dbg_state
);

    // Handshake: start is accepted on any edge where busy=0 (IDLE or DONE);
    // done pulses for exactly one cycle with o valid, and o then holds until
    // the next accepted start. start while busy=1 is dropped, never queued.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [SHIFT-1:0] cnt;
    logic             dir_q;
    logic             fill;
    logic             accept;

`ifdef SEQ_SHIFTER_ARITH_EN
    logic arith_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            arith_q <= 1'b0;
        end else if (accept) begin
            arith_q <= arith;
        end
    end

    // o[MSB] never changes during an arithmetic right shift, so it is the latched sign.
    assign fill = arith_q & o[WIDTH-1];
`else
    logic unused_arith;

    assign unused_arith = arith;
    assign fill         = 1'b0;
`endif

    assign accept = start && (state != S_SHIFT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            o     <= '0;
            cnt   <= '0;
            dir_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                o     <= a;
                cnt   <= b;
                dir_q <= dir;
            end else if (state == S_SHIFT) begin
                cnt <= cnt - 1'b1;
                if (dir_q) begin
                    o <= {fill, o[WIDTH-1:1]};
                end else begin
                    o <= {o[WIDTH-2:0], 1'b0};
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt = (b == '0) ? S_DONE : S_SHIFT;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (cnt == SHIFT'(1)) begin
                    state_nxt = S_DONE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy      = (state == S_SHIFT);
    assign done      = (state == S_DONE);
    assign dbg_state = state;

endmodule

// File: doc/seq_shifter.md
# seq_shifter

Multi-cycle iterative shifter for the integer datapath: it shifts an operand left or right by a variable amount, one bit position per clock, under a start/done handshake. It is the sequential, area-reduced counterpart of the combinational barrel `shifter`, and uses the same operand and direction encoding. Cores that cannot afford a full barrel shifter on the ALU path use it as a multicycle shift unit.

## Interface
Parameters:
- `WIDTH`, 32: operand and result width in bits.
- `SHIFT`, `$clog2(WIDTH)`: width of the shift-amount port.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  request; sampled only when `busy`=0.
- `a`  in  `WIDTH`  operand; captured when `start` is accepted.
- `b`  in  `SHIFT`  shift amount; captured when `start` is accepted.
- `dir`  in  1  0 = shift left, 1 = shift right; captured when `start` is accepted.
- `arith`  in  1  right-shift fill select (see Configuration); captured when `start` is accepted.
- `busy`  out  1  high while a shift is in progress.
- `done`  out  1  one-cycle pulse; `o` is valid in this cycle.
- `o`  out  `WIDTH`  result register.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE or DONE, with `start`=1:
  - Load `o`←`a` and `cnt`←`b`, and latch `dir` and `arith`.
  - Next state is DONE if `b`=0, otherwise SHIFT.
- IDLE or DONE, with `start`=0: next state is IDLE.
- SHIFT, on each edge:
  - Shift `o` by one position and decrement `cnt`.
  - When `cnt` was 1 before this edge, the next state is DONE.
- Shift fill rules:
  - Left shift: shift in 0 at the LSB.
  - Right shift: shift in 0 at the MSB, or the latched MSB when arithmetic is enabled and selected.
- `busy` = (state == SHIFT).
- `done` = (state == DONE).
- `o` holds its value from DONE until the next accepted `start`. While busy, `o` shows intermediate values and is not valid.
- `start` while `busy`=1 is ignored; it is neither queued nor stretched.
- `start` in the DONE cycle is accepted (back-to-back operation).
- `b` values at or above `WIDTH` cannot occur, because `SHIFT` bits cover 0..`WIDTH`-1 exactly for power-of-two `WIDTH`.
- Reset (`rst`=1 at an edge, including mid-shift):
  - State→IDLE; `o`=0, `cnt`=0, `busy`=0, `done`=0.
  - Any in-flight operation is discarded with no `done` pulse.
  - Reset has priority over `start`.

## Timing
- `start` is asserted in cycle C0 and accepted at the end of C0.
- `done` is high in cycle C(b+1). Latency is b+1 cycles:
  - b=0 gives 1 cycle.
  - b=WIDTH-1 gives WIDTH cycles.
- `busy` is high in cycles C1..Cb, i.e. b cycles; it is never high when b=0.
- Throughput: one new operation every b+1 cycles when `start` is held high.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `SEQ_SHIFTER_ARITH_EN` defined:
  - Right shifts with latched `arith`=1 replicate the operand's MSB.
  - `arith`=0 gives a logical right shift.
  - Left shifts are unaffected by `arith`.
- `SEQ_SHIFTER_ARITH_EN` undefined:
  - The `arith` port is present but ignored.
  - All right shifts are logical (zero fill).
  - The `arith` latch and MSB-fill logic are not built.

## Test plan
- After reset: `busy`=0, `done`=0, `o`=0. Then `a`=32'h0000_0031, `b`=5, `dir`=0, `start`=1 for one cycle → `busy` high for 5 cycles; `done` in C6; `o`=32'h0000_0620.
- `a`=32'h8000_0000, `b`=31, `dir`=1, `arith`=0 → `done` in C32; `o`=32'h0000_0001.
- `a`=32'hF000_0000, `b`=4, `dir`=1, `arith`=1:
  - With the macro: `o`=32'hFF00_0000.
  - Without the macro: `o`=32'h0F00_0000.
  - In both cases `done` is in C5.
- `a`=32'hDEAD_BEEF, `b`=0 → `done` in C1, `busy` never high, `o`=32'hDEAD_BEEF.
- Start `b`=10, then pulse `start` with new operands in C3 → second request ignored; `done` in C11 with the first result. Then `start` held high in the DONE cycle → new operation accepted immediately.
- Start `b`=20, assert `rst` in C5 → next cycle `busy`=0, `o`=0, no `done` pulse. A fresh `start` after reset completes normally.
